// File: rtl/my_nios1_sysid_pkg.sv
// Shared types and constants for the system-ID boot checker.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package my_nios1_sysid_pkg;

    localparam int SYSID_W = 32;

    localparam logic SYSID_ADDR_ID = 1'b0;
    localparam logic SYSID_ADDR_TS = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_ID,
        ST_RD_TS,
        ST_GAP,
        ST_CHECK,
        ST_DONE
    } sysid_state_t;

    // True in the states that hold an Avalon read outstanding.
    function automatic logic sysid_is_read(input sysid_state_t s);
        return (s == ST_RD_ID) || (s == ST_RD_TS);
    endfunction

endpackage

// File: rtl/my_nios1_sysid_checker_if.sv
// Avalon-MM read-only link between the checker (master) and the sysid slave.
// Latency: n/a (wires only).
// Backpressure: slave stalls the master with avm_waitrequest.
// Signals: avm_address (word addr), avm_read (strobe), avm_readdata, avm_waitrequest.
interface my_nios1_sysid_checker_if;
    import my_nios1_sysid_pkg::*;

    logic               avm_address;
    logic               avm_read;
    logic [SYSID_W-1:0] avm_readdata;
    logic               avm_waitrequest;

    modport master (
        output avm_address,
        output avm_read,
        input  avm_readdata,
        input  avm_waitrequest
    );

    modport slave (
        input  avm_address,
        input  avm_read,
        output avm_readdata,
        output avm_waitrequest
    );
endinterface

// File: rtl/my_nios1_sysid_stall_timer.sv
// Counts consecutive stalled cycles of one read and flags the last allowed one.
// Latency: count updates one cycle after i_en; o_expire is combinational from the count.
// Backpressure: none; i_clr has priority over i_en, the count never wraps.
// Ports: clock, reset (async, active-high), i_clr, i_en, o_expire.
module my_nios1_sysid_stall_timer #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic clock,
    input  logic reset,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expire
);
    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && !o_expire) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_expire = (r_cnt == LAST);

endmodule

// File: rtl/my_nios1_sysid_checker.sv
// Boot-time sequencer: reads sysid ID (addr 0) and timestamp (addr 1), compares, reports flags.
// Latency: zero wait states -> start at edge N, reads in N+1/N+2, done/id_ok/ts_ok after edge N+3.
// Backpressure: holds address/read while waitrequest; aborts a read after TIMEOUT_CYCLES stalled cycles.
// Ports: clock, reset (async, active-high), start, avm (master modport), busy, done,
//        id_ok, ts_ok, timeout, id_value, ts_value.
// Build option: SYSID_CHECK_AUTOSTART_EN fires one internal start on the first clock after reset.
module my_nios1_sysid_checker
    import my_nios1_sysid_pkg::*;
#(
    parameter logic [SYSID_W-1:0] EXP_ID         = 32'h0000_0000,
    parameter logic [SYSID_W-1:0] EXP_TS         = 32'd1506524032,
    parameter int                 TIMEOUT_CYCLES = 256,
    parameter int                 MAX_RETRIES    = 3
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    my_nios1_sysid_checker_if.master avm,
    output logic                  busy,
    output logic                  done,
    output logic                  id_ok,
    output logic                  ts_ok,
    output logic                  timeout,
    output logic [SYSID_W-1:0]    id_value,
    output logic [SYSID_W-1:0]    ts_value
);
    localparam int RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
    localparam logic [RW-1:0] RMAX = RW'(MAX_RETRIES);

    sysid_state_t       r_state;
    logic [RW-1:0]      r_retries;
    logic               r_avm_read;
    logic               r_avm_address;
    logic               r_busy;
    logic               r_done;
    logic               r_id_ok;
    logic               r_ts_ok;
    logic               r_timeout;
    logic [SYSID_W-1:0] r_id_value;
    logic [SYSID_W-1:0] r_ts_value;

    logic w_start;
    logic w_rd;
    logic w_accept;
    logic w_expire;
    logic w_abort;
    logic w_stall_en;
    logic w_stall_clr;

`ifdef SYSID_CHECK_AUTOSTART_EN
    // One-shot: low only until the first clock edge after reset releases.
    logic r_auto_fired;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_auto_fired <= 1'b0;
        end else begin
            r_auto_fired <= 1'b1;
        end
    end

    assign w_start = start | ~r_auto_fired;
`else
    assign w_start = start;
`endif

    assign w_rd        = sysid_is_read(r_state);
    assign w_accept    = w_rd && !avm.avm_waitrequest;
    assign w_stall_en  = w_rd && avm.avm_waitrequest;
    assign w_abort     = w_stall_en && w_expire;
    // Counter sits at zero whenever no read is pending, so each read starts fresh.
    assign w_stall_clr = w_accept || w_abort || !w_rd;

    my_nios1_sysid_stall_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_stall_timer (
        .clock    (clock),
        .reset    (reset),
        .i_clr    (w_stall_clr),
        .i_en     (w_stall_en),
        .o_expire (w_expire)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_retries     <= '0;
            r_avm_read    <= 1'b0;
            r_avm_address <= SYSID_ADDR_ID;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_id_ok       <= 1'b0;
            r_ts_ok       <= 1'b0;
            r_timeout     <= 1'b0;
            r_id_value    <= '0;
            r_ts_value    <= '0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (w_start) begin
                        r_done        <= 1'b0;
                        r_id_ok       <= 1'b0;
                        r_ts_ok       <= 1'b0;
                        r_timeout     <= 1'b0;
                        r_retries     <= '0;
                        r_busy        <= 1'b1;
                        r_avm_read    <= 1'b1;
                        r_avm_address <= SYSID_ADDR_ID;
                        r_state       <= ST_RD_ID;
                    end
                end
                ST_RD_ID, ST_RD_TS: begin
                    if (w_accept) begin
                        if (r_state == ST_RD_ID) begin
                            r_id_value    <= avm.avm_readdata;
                            r_avm_address <= SYSID_ADDR_TS;
                            r_state       <= ST_RD_TS;
                        end else begin
                            r_ts_value    <= avm.avm_readdata;
                            r_avm_read    <= 1'b0;
                            r_state       <= ST_CHECK;
                        end
                    end else if (w_abort) begin
                        r_avm_read <= 1'b0;
                        if (r_retries != RMAX) begin
                            r_retries <= r_retries + 1'b1;
                        end
                        r_state <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (r_retries == RMAX) begin
                        r_timeout <= 1'b1;
                        r_done    <= 1'b1;
                        r_busy    <= 1'b0;
                        r_state   <= ST_DONE;
                    end else begin
                        // A retry always re-reads the ID so both values come from one pass.
                        r_avm_read    <= 1'b1;
                        r_avm_address <= SYSID_ADDR_ID;
                        r_state       <= ST_RD_ID;
                    end
                end
                ST_CHECK: begin
                    r_id_ok <= (r_id_value == EXP_ID);
                    r_ts_ok <= (r_ts_value == EXP_TS);
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= ST_DONE;
                end
                default: begin
                    r_avm_read <= 1'b0;
                    r_busy     <= 1'b0;
                    r_state    <= ST_IDLE;
                end
            endcase
        end
    end

    assign avm.avm_read    = r_avm_read;
    assign avm.avm_address = r_avm_address;
    assign busy            = r_busy;
    assign done            = r_done;
    assign id_ok           = r_id_ok;
    assign ts_ok           = r_ts_ok;
    assign timeout         = r_timeout;
    assign id_value        = r_id_value;
    assign ts_value        = r_ts_value;

endmodule
